// File: rtl/axi4lite_mem_ctrl.sv
// axi4lite_mem_ctrl
// AXI4-Lite slave front-end for a single-port word memory. The AW, W and AR
// channels are captured into independent holding registers. One memory
// operation runs at a time. When a read and a write are both pending, the
// grant alternates between them. Memory response codes are translated into
// AXI B/R responses.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   s_aw*, s_w*, s_b*           AXI4-Lite write address / data / response
//   s_ar*, s_r*                 AXI4-Lite read address / data
//   mem_wen, mem_aw/wstrb/wdata write request to memory; mem_wresp/mem_wdone back
//   mem_ren, mem_araddr         read request to memory; mem_rdata/rresp/rdone back
//   wr_cnt, rd_cnt, err_cnt     saturating performance counters; these ports
//                               exist only when PERF_CNT_EN is defined
//
// Build option: `define PERF_CNT_EN adds the performance counter outputs.
module axi4lite_mem_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int DATA_DEPTH     = 64,
  parameter int ADDR_WIDTH     = $clog2(DATA_DEPTH),
  parameter int AXI_ADDR_WIDTH = ADDR_WIDTH + 2,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int MEM_TIMEOUT    = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [AXI_ADDR_WIDTH-1:0] s_awaddr,
  input  logic                      s_awvalid,
  output logic                      s_awready,
  input  logic [DATA_WIDTH-1:0]     s_wdata,
  input  logic [STRB_WIDTH-1:0]     s_wstrb,
  input  logic                      s_wvalid,
  output logic                      s_wready,
  output logic [1:0]                s_bresp,
  output logic                      s_bvalid,
  input  logic                      s_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_araddr,
  input  logic                      s_arvalid,
  output logic                      s_arready,
  output logic [DATA_WIDTH-1:0]     s_rdata,
  output logic [1:0]                s_rresp,
  output logic                      s_rvalid,
  input  logic                      s_rready,
  output logic                      mem_wen,
  output logic [ADDR_WIDTH-1:0]     mem_awaddr,
  output logic [STRB_WIDTH-1:0]     mem_wstrb,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [1:0]                mem_wresp,
  input  logic                      mem_wdone,
  output logic                      mem_ren,
  output logic [ADDR_WIDTH-1:0]     mem_araddr,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  input  logic [1:0]                mem_rresp,
  input  logic                      mem_rdone
`ifdef PERF_CNT_EN
  ,
  output logic [15:0]               wr_cnt,
  output logic [15:0]               rd_cnt,
  output logic [15:0]               err_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, WR_MEM, WR_RESP, RD_MEM, RD_RESP} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int              TMO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  function automatic logic [1:0] xlate(input logic [1:0] r);
    case (r)
      2'b00:   xlate = RESP_OKAY;
      2'b11:   xlate = RESP_DECERR;
      default: xlate = RESP_SLVERR;
    endcase
  endfunction

  // Holding registers
  logic                  aw_held_q, w_held_q, ar_held_q;
  logic                  aw_held_d, w_held_d, ar_held_d;
  logic                  awready_q, wready_q, arready_q;
  logic [ADDR_WIDTH-1:0] awaddr_q, araddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;

  // FSM and registered outputs
  state_t                state_q;
  logic [TMO_W-1:0]      tmo_q;
  logic                  last_wr_q;   // 1: last grant went to the write path
  logic                  mem_wen_q, mem_ren_q;
  logic [ADDR_WIDTH-1:0] mem_awaddr_q, mem_araddr_q;
  logic [STRB_WIDTH-1:0] mem_wstrb_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  bvalid_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic aw_hs, w_hs, ar_hs;
  logic wr_pend, rd_pend, grant_wr, grant_rd;
  logic tmo_hit, wr_leave, rd_leave;

  // Byte-offset bits of the AXI addresses carry no information for word access.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

  always_comb begin
    aw_hs     = s_awvalid && awready_q;
    w_hs      = s_wvalid  && wready_q;
    ar_hs     = s_arvalid && arready_q;
    wr_pend   = aw_held_q && w_held_q;
    rd_pend   = ar_held_q;
    grant_wr  = wr_pend && (!rd_pend || !last_wr_q);
    grant_rd  = rd_pend && !grant_wr;
    tmo_hit   = (tmo_q == TMO_LAST);
    wr_leave  = (state_q == WR_MEM) && (mem_wdone || tmo_hit);
    rd_leave  = (state_q == RD_MEM) && (mem_rdone || tmo_hit);
    // A handshake needs an empty holder, and a release needs a full one,
    // so the two never coincide on the same flag.
    aw_held_d = aw_hs || (aw_held_q && !wr_leave);
    w_held_d  = w_hs  || (w_held_q  && !wr_leave);
    ar_held_d = ar_hs || (ar_held_q && !rd_leave);
  end

  // Ready is registered as the inverse of the next-cycle holder state so that
  // it reads 0 during reset and 1 whenever the holder is empty.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      ar_held_q <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      ar_held_q <= ar_held_d;
      awready_q <= !aw_held_d;
      wready_q  <= !w_held_d;
      arready_q <= !ar_held_d;
      if (aw_hs) awaddr_q <= s_awaddr[ADDR_WIDTH+1:2];
      if (ar_hs) araddr_q <= s_araddr[ADDR_WIDTH+1:2];
      if (w_hs) begin
        wdata_q <= s_wdata;
        wstrb_q <= s_wstrb;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      tmo_q        <= '0;
      last_wr_q    <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_ren_q    <= 1'b0;
      mem_awaddr_q <= '0;
      mem_araddr_q <= '0;
      mem_wstrb_q  <= '0;
      mem_wdata_q  <= '0;
      bvalid_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      bresp_q      <= '0;
      rresp_q      <= '0;
      rdata_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (grant_wr) begin
            state_q      <= WR_MEM;
            last_wr_q    <= 1'b1;
            mem_wen_q    <= 1'b1;
            mem_awaddr_q <= awaddr_q;
            mem_wstrb_q  <= wstrb_q;
            mem_wdata_q  <= wdata_q;
          end else if (grant_rd) begin
            state_q      <= RD_MEM;
            last_wr_q    <= 1'b0;
            mem_ren_q    <= 1'b1;
            mem_araddr_q <= araddr_q;
          end
        end
        WR_MEM: begin
          tmo_q <= tmo_q + TMO_W'(1);
          if (wr_leave) begin
            state_q   <= WR_RESP;
            mem_wen_q <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= mem_wdone ? RESP_OKAY : xlate(mem_wresp);
          end
        end
        WR_RESP: begin
          if (s_bready) begin
            state_q  <= IDLE;
            bvalid_q <= 1'b0;
          end
        end
        RD_MEM: begin
          tmo_q <= tmo_q + TMO_W'(1);
          if (rd_leave) begin
            state_q   <= RD_RESP;
            mem_ren_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rresp_q   <= mem_rdone ? RESP_OKAY : xlate(mem_rresp);
            rdata_q   <= mem_rdone ? mem_rdata : '0;
          end
        end
        RD_RESP: begin
          if (s_rready) begin
            state_q  <= IDLE;
            rvalid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_awready  = awready_q;
  assign s_wready   = wready_q;
  assign s_arready  = arready_q;
  assign s_bvalid   = bvalid_q;
  assign s_bresp    = bresp_q;
  assign s_rvalid   = rvalid_q;
  assign s_rresp    = rresp_q;
  assign s_rdata    = rdata_q;
  assign mem_wen    = mem_wen_q;
  assign mem_awaddr = mem_awaddr_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_ren    = mem_ren_q;
  assign mem_araddr = mem_araddr_q;

`ifdef PERF_CNT_EN
  logic [15:0] wr_cnt_q, rd_cnt_q, err_cnt_q;
  logic        b_hs, r_hs, err_hs;

  always_comb begin
    b_hs   = bvalid_q && s_bready;
    r_hs   = rvalid_q && s_rready;
    err_hs = (b_hs && (bresp_q != RESP_OKAY)) || (r_hs && (rresp_q != RESP_OKAY));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      if (b_hs && (wr_cnt_q != '1))    wr_cnt_q  <= wr_cnt_q + 16'd1;
      if (r_hs && (rd_cnt_q != '1))    rd_cnt_q  <= rd_cnt_q + 16'd1;
      if (err_hs && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign wr_cnt  = wr_cnt_q;
  assign rd_cnt  = rd_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_axi4lite_mem_ctrl.sv
// Testbench for axi4lite_mem_ctrl: a behavioural word memory with a
// configurable completion delay and response code, a table of single
// transactions, and hand-written sequences for arbitration, response
// back-pressure and reset during a memory operation.
module tb_axi4lite_mem_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  s_awaddr, s_araddr;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_arvalid, s_arready;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_bvalid, s_bready, s_rvalid, s_rready;
  logic        mem_wen, mem_ren, mem_wdone, mem_rdone;
  logic [5:0]  mem_awaddr, mem_araddr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata, mem_rdata;
  logic [1:0]  mem_wresp, mem_rresp;
`ifdef PERF_CNT_EN
  logic [15:0] wr_cnt, rd_cnt, err_cnt;
`endif

  always #5 clk = ~clk;

  axi4lite_mem_ctrl #(.DATA_WIDTH(32), .DATA_DEPTH(64), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .resetn(resetn),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .mem_wen(mem_wen), .mem_awaddr(mem_awaddr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_wresp(mem_wresp), .mem_wdone(mem_wdone),
    .mem_ren(mem_ren), .mem_araddr(mem_araddr),
    .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rdone(mem_rdone)
`ifdef PERF_CNT_EN
    , .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .err_cnt(err_cnt)
`endif
  );

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  // cfg_dly = N: done asserted in the N-th cycle of the request; 0 = never.
  logic [31:0] mem [64];
  int          cfg_dly;
  logic [1:0]  cfg_resp;
  int          wcnt, rcnt, last_wlen, last_rlen;
  logic [5:0]  last_waddr, last_raddr;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem_wdone = 1'b0; mem_rdone = 1'b0; mem_rdata = '0;
    mem_wresp = '0;   mem_rresp = '0;
    wcnt = 0; rcnt = 0; last_wlen = 0; last_rlen = 0;
    last_waddr = '0; last_raddr = '0;
    forever begin
      @(negedge clk);
      mem_wresp = cfg_resp;
      mem_rresp = cfg_resp;
      if (!resetn) begin
        wcnt = 0; rcnt = 0; mem_wdone = 1'b0; mem_rdone = 1'b0;
        mem_rdata = 32'h5A5A5A5A;
      end else begin
        if (mem_wen) begin
          wcnt++;
          last_waddr = mem_awaddr;
          mem_wdone = (wcnt == cfg_dly);
          if (mem_wdone)
            for (int b = 0; b < 4; b++)
              if (mem_wstrb[b]) mem[mem_awaddr][8*b +: 8] = mem_wdata[8*b +: 8];
        end else begin
          if (wcnt != 0) last_wlen = wcnt;
          wcnt = 0;
          mem_wdone = 1'b0;
        end
        if (mem_ren) begin
          rcnt++;
          last_raddr = mem_araddr;
          mem_rdone = (rcnt == cfg_dly);
        end else begin
          if (rcnt != 0) last_rlen = rcnt;
          rcnt = 0;
          mem_rdone = 1'b0;
        end
        mem_rdata = mem_rdone ? mem[mem_araddr] : 32'h5A5A5A5A;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic [1:0] resp; logic [31:0] data; } rexp_t;
  logic [1:0] exp_b [$];
  rexp_t      exp_r [$];

  initial begin
    logic [1:0] eb;
    rexp_t      er;
    forever begin
      @(negedge clk); #1;
      if (resetn === 1'b1 && s_bvalid && s_bready) begin
        if (exp_b.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL b_unexpected: got bresp %b with nothing expected", s_bresp);
        end else begin
          eb = exp_b.pop_front();
          check("bresp", 32'(s_bresp), 32'(eb));
        end
      end
      if (resetn === 1'b1 && s_rvalid && s_rready) begin
        if (exp_r.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL r_unexpected: got rresp %b rdata 0x%0h with nothing expected", s_rresp, s_rdata);
        end else begin
          er = exp_r.pop_front();
          check("rresp", 32'(s_rresp), 32'(er.resp));
          check("rdata", s_rdata, er.data);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit aw, input bit w, input bit ar);
    bit aw_go, w_go, ar_go;
    s_awvalid = aw; s_wvalid = w; s_arvalid = ar;
    for (int i = 0; i < 40; i++) begin
      aw_go = s_awvalid && s_awready;
      w_go  = s_wvalid  && s_wready;
      ar_go = s_arvalid && s_arready;
      @(negedge clk);
      if (aw_go) s_awvalid = 1'b0;
      if (w_go)  s_wvalid  = 1'b0;
      if (ar_go) s_arvalid = 1'b0;
      if (!s_awvalid && !s_wvalid && !s_arvalid) break;
    end
    if (s_awvalid || s_wvalid || s_arvalid) begin
      nvec++; nerr++;
      $display("FAIL handshake_timeout: got valids %b%b%b still pending, expected 000",
               s_awvalid, s_wvalid, s_arvalid);
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    end
  endtask

  task automatic wait_valid(input bit rch);
    logic v;
    v = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      v = rch ? s_rvalid : s_bvalid;
      if (v) break;
    end
    check(rch ? "rvalid_arrives" : "bvalid_arrives", 32'(v), 32'd1);
  endtask

  // kind: 1 = write started, 0 = read started, -1 = nothing within bound
  task automatic wait_op(output int kind);
    kind = -1;
    for (int i = 0; i < 60; i++) begin
      if (!mem_wen && !mem_ren) break;
      @(negedge clk); #1;
    end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (mem_wen) begin kind = 1; break; end
      if (mem_ren) begin kind = 0; break; end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  mresp;
    int          dly;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
    int          exp_len;
  } vec_t;
  vec_t vecs [12];

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    int kind;
    //            wr    addr   data          strb   mresp  dly exp   exp_data      len
    vecs[0]  = '{1'b1, 8'h28, 32'hDEADBEEF, 4'hF, 2'b00, 2, 2'b00, 32'h0,        2};
    vecs[1]  = '{1'b1, 8'h04, 32'h11111111, 4'hF, 2'b01, 0, 2'b10, 32'h0,        4};
    vecs[2]  = '{1'b0, 8'hFC, 32'h0,        4'h0, 2'b11, 0, 2'b11, 32'h00000000, 4};
    vecs[3]  = '{1'b0, 8'h28, 32'h0,        4'h0, 2'b00, 1, 2'b00, 32'hDEADBEEF, 1};
    vecs[4]  = '{1'b1, 8'h10, 32'hA5A5A5A5, 4'h5, 2'b00, 3, 2'b00, 32'h0,        3};
    vecs[5]  = '{1'b0, 8'h12, 32'h0,        4'h0, 2'b00, 2, 2'b00, 32'h00A500A5, 2};
    vecs[6]  = '{1'b1, 8'h30, 32'h99999999, 4'hF, 2'b10, 0, 2'b10, 32'h0,        4};
    vecs[7]  = '{1'b0, 8'h30, 32'h0,        4'h0, 2'b00, 1, 2'b00, 32'h00000000, 1};
    vecs[8]  = '{1'b1, 8'h08, 32'h55555555, 4'hF, 2'b11, 0, 2'b11, 32'h0,        4};
    vecs[9]  = '{1'b0, 8'h08, 32'h0,        4'h0, 2'b01, 0, 2'b10, 32'h00000000, 4};
    vecs[10] = '{1'b1, 8'h08, 32'h12345678, 4'hF, 2'b01, 1, 2'b00, 32'h0,        1};
    vecs[11] = '{1'b0, 8'h09, 32'h0,        4'h0, 2'b10, 2, 2'b00, 32'h12345678, 2};

    resetn = 1'b1;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_araddr = '0; s_arvalid = 1'b0; s_bready = 1'b1; s_rready = 1'b1;
    cfg_dly = 1; cfg_resp = 2'b00;

    // Reset state
    #3 resetn = 1'b0;
    #5;
    check("reset_ctrl", 32'({s_awready, s_wready, s_arready, s_bvalid, s_rvalid,
                             mem_wen, mem_ren, s_bresp, s_rresp}), 32'd0);
    check("reset_rdata", s_rdata, 32'd0);
    check("reset_mem_addr", 32'({mem_awaddr, mem_araddr, mem_wstrb}), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk); #1;
    check("ready_after_reset", 32'({s_awready, s_wready, s_arready}), 32'h7);

    // Table of single transactions
    for (int i = 0; i < 12; i++) begin
      cfg_resp = vecs[i].mresp;
      cfg_dly  = vecs[i].dly;
      last_wlen = 0; last_rlen = 0;
      if (vecs[i].wr) begin
        exp_b.push_back(vecs[i].exp_resp);
        s_awaddr = vecs[i].addr; s_wdata = vecs[i].data; s_wstrb = vecs[i].strb;
        drive(1'b1, 1'b1, 1'b0);
        wait_valid(1'b0);
        check("wen_cycles", 32'(last_wlen), 32'(vecs[i].exp_len));
        check("mem_awaddr", 32'(last_waddr), 32'(vecs[i].addr >> 2));
      end else begin
        exp_r.push_back('{vecs[i].exp_resp, vecs[i].exp_data});
        s_araddr = vecs[i].addr;
        drive(1'b0, 1'b0, 1'b1);
        wait_valid(1'b1);
        check("ren_cycles", 32'(last_rlen), 32'(vecs[i].exp_len));
        check("mem_araddr", 32'(last_raddr), 32'(vecs[i].addr >> 2));
      end
      @(negedge clk); #1;
    end

    // W arrives three cycles before AW: memory must stay idle until AW lands
    cfg_dly = 1; cfg_resp = 2'b00;
    s_wdata = 32'h13579BDF; s_wstrb = 4'hF;
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("no_mem_before_aw", 32'({mem_wen, mem_ren}), 32'd0);
    end
    exp_b.push_back(2'b00);
    s_awaddr = 8'h3C;
    drive(1'b1, 1'b0, 1'b0);
    wait_valid(1'b0);
    check("late_aw_addr", 32'(last_waddr), 32'hF);
    @(negedge clk); #1;
    exp_r.push_back('{2'b00, 32'h13579BDF});
    s_araddr = 8'h3C;
    drive(1'b0, 1'b0, 1'b1);
    wait_valid(1'b1);
    @(negedge clk); #1;

    // Arbitration: first contention after reset goes to write, then alternates
    do_reset();
    cfg_dly = 1; cfg_resp = 2'b00;
    s_bready = 1'b0;
    s_awaddr = 8'h40; s_wdata = 32'h0BADF00D; s_wstrb = 4'hF; s_araddr = 8'h28;
    exp_b.push_back(2'b00);
    exp_r.push_back('{2'b00, 32'hDEADBEEF});
    drive(1'b1, 1'b1, 1'b1);
    wait_op(kind);
    check("arb_first_is_write", 32'(kind), 32'd1);
    wait_valid(1'b0);
    s_awaddr = 8'h44; s_wdata = 32'h0000CAFE;
    exp_b.push_back(2'b00);
    drive(1'b1, 1'b1, 1'b0);
    s_bready = 1'b1;
    wait_op(kind);
    check("arb_second_is_read", 32'(kind), 32'd0);
    wait_op(kind);
    check("arb_third_is_write", 32'(kind), 32'd1);
    for (int i = 0; i < 40; i++) begin
      if (exp_b.size() == 0 && exp_r.size() == 0) break;
      @(negedge clk); #1;
    end
    check("arb_drained", 32'(exp_b.size() + exp_r.size()), 32'd0);
    @(negedge clk); #1;

    // B back-pressure with a read captured during the stall
    cfg_dly = 1; cfg_resp = 2'b00;
    s_bready = 1'b0;
    s_awaddr = 8'h20; s_wdata = 32'h00000077; s_wstrb = 4'hF;
    exp_b.push_back(2'b00);
    drive(1'b1, 1'b1, 1'b0);
    wait_valid(1'b0);
    s_araddr = 8'h20;
    exp_r.push_back('{2'b00, 32'h00000077});
    drive(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("stall_bvalid", 32'(s_bvalid), 32'd1);
      check("stall_bresp", 32'(s_bresp), 32'd0);
      check("stall_no_read", 32'(mem_ren), 32'd0);
    end
    @(negedge clk);
    s_bready = 1'b1;
    @(negedge clk); #1;
    check("post_b_idle", 32'(mem_ren), 32'd0);
    @(negedge clk); #1;
    check("post_b_read_granted", 32'(mem_ren), 32'd1);
    wait_valid(1'b1);
    @(negedge clk); #1;

    // Reset during WR_MEM: operation abandoned, no response
    cfg_dly = 0; cfg_resp = 2'b00;
    s_awaddr = 8'h48; s_wdata = 32'hFFFF0000; s_wstrb = 4'hF;
    drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (mem_wen) break;
      @(negedge clk); #1;
    end
    check("wen_before_reset", 32'(mem_wen), 32'd1);
    resetn = 1'b0;
    #1;
    check("reset_drops_wen", 32'({mem_wen, s_bvalid}), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    check("no_resp_after_reset", 32'({mem_wen, mem_ren, s_bvalid, s_rvalid}), 32'd0);
    check("queues_empty", 32'(exp_b.size() + exp_r.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/axi4lite_mem_ctrl.md
Name: axi4lite_mem_ctrl

Overview:
AXI4-Lite slave front-end that sequences the single-port word memory block (WEN/REN request, WDONE/RDONE completion, 2-bit memory response). It accepts AW/W/AR channels, arbitrates between pending reads and writes, and drives exactly one memory operation at a time. It translates memory response codes into AXI B/R responses. The block sits between the interconnect and the memory; together they form the axi4lite slave.

Parameters:
DATA_WIDTH, 32, AXI and memory data width; only 32 is supported (4 strobe bits).
DATA_DEPTH, 64, memory depth in words.
ADDR_WIDTH, $clog2(DATA_DEPTH), memory word-address width.
AXI_ADDR_WIDTH, ADDR_WIDTH+2, AXI byte-address width.
STRB_WIDTH, DATA_WIDTH/8, write-strobe width.
MEM_TIMEOUT, 4, cycles to wait for WDONE/RDONE before sampling an error response.

Ports:
clk  in  1  clock
resetn  in  1  async active-low reset
s_awaddr  in  AXI_ADDR_WIDTH  write address
s_awvalid  in  1  / s_awready  out  1
s_wdata  in  DATA_WIDTH  / s_wstrb  in  STRB_WIDTH
s_wvalid  in  1  / s_wready  out  1
s_bresp  out  2  / s_bvalid  out  1  / s_bready  in  1
s_araddr  in  AXI_ADDR_WIDTH  / s_arvalid  in  1  / s_arready  out  1
s_rdata  out  DATA_WIDTH  / s_rresp  out  2  / s_rvalid  out  1  / s_rready  in  1
mem_wen  out  1  / mem_awaddr  out  ADDR_WIDTH  / mem_wstrb  out  STRB_WIDTH  / mem_wdata  out  DATA_WIDTH
mem_wresp  in  2  / mem_wdone  in  1
mem_ren  out  1  / mem_araddr  out  ADDR_WIDTH
mem_rdata  in  DATA_WIDTH  / mem_rresp  in  2  / mem_rdone  in  1

Behaviour:
- Reset: all outputs 0; FSM=IDLE; AW/W/AR capture flags cleared; last_grant=READ, so the first contention goes to write.
- Capture: s_awready=1 while the AW holding register is empty; likewise W and AR. Each channel handshakes on valid&&ready and is captured independently. AW and W may arrive in either order or in the same cycle.
- Address: memory word address = axaddr[ADDR_WIDTH+1:2]. Low 2 bits are ignored.
- FSM states: IDLE, WR_MEM, WR_RESP, RD_MEM, RD_RESP.
- IDLE: a write is pending when both AW and W are held; a read is pending when AR is held.
  - Only one pending: grant it.
  - Both pending: grant the opposite of last_grant, then update last_grant.
  - Grant to WR_MEM or RD_MEM takes 1 cycle.
- WR_MEM: mem_wen=1 with held addr/strb/data until mem_wdone=1 or MEM_TIMEOUT cycles elapse, then clear mem_wen.
  - Done: bresp=OKAY.
  - Timeout: bresp = translated mem_wresp sampled on the timeout cycle.
  - Go to WR_RESP. Clear the AW and W holding flags on leaving WR_MEM.
- RD_MEM: mem_ren=1 until mem_rdone or timeout, same rules.
  - Done: s_rdata = mem_rdata, rresp=OKAY.
  - Timeout: s_rdata = 0, rresp translated.
  - Clear the AR holding flag on leaving RD_MEM.
- Translation (memory to AXI): 2'b00→OKAY 2'b00; 2'b01→SLVERR 2'b10; 2'b11→DECERR 2'b11; 2'b10→SLVERR.
- WR_RESP/RD_RESP: bvalid/rvalid high with stable payload until the ready handshake, then return to IDLE. Ready already high gives a 1-cycle response phase.
- Minimum latency, last channel handshake to B/R valid: grant 1 + memory completion + 1 cycle.
- New AW/W/AR may be captured during any state; they are serviced after return to IDLE. At most one outstanding transaction per channel.
- Reset mid-transaction: the operation is abandoned, mem_wen/mem_ren drop immediately, and no response is issued.

Optional Feature:
PERF_CNT_EN:
- Defined: adds outputs wr_cnt[15:0], rd_cnt[15:0], err_cnt[15:0], all reset to 0 and saturating at 16'hFFFF.
  - wr_cnt/rd_cnt increment on each B/R handshake.
  - err_cnt increments on any B/R handshake with a non-OKAY response.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- AW=0x28, W=0xDEADBEEF, strb=4'hF in the same cycle; memory gives WDONE 2 cycles later → mem_wen high exactly until WDONE; bresp=2'b00; later read of 0x28 → rdata=0xDEADBEEF, rresp=2'b00.
- Write to 0x04 with memory returning wresp=2'b01 and no WDONE → mem_wen drops after 4 cycles; bresp=2'b10.
- Read of 0xFC with memory rresp=2'b11 and no RDONE → rresp=2'b11, rdata=0.
- W presented 3 cycles before AW → no memory access until AW is captured, then a normal write with OKAY.
- Write and read both pending in IDLE after reset → write granted first. With both pending again, read is granted next (alternation).
- bready held low 5 cycles → bvalid/bresp stable; a new AR is captured meanwhile and serviced right after the B handshake. Reset asserted during WR_MEM → mem_wen=0 and bvalid=0 immediately.
